// File: rtl/wb_regfile_commit.sv
// -----------------------------------------------------------------------------
// wb_regfile_commit
//
// Consumer end of the writeback path. The MEM/WB bundle is registered into a
// one-entry pending stage (the "commit" registers). One edge later the pending
// write lands in a 2**ADDR_W-entry register file. Two combinational read ports
// serve decode. Each port bypasses the pending write, so a result is visible
// on the read ports one edge earlier than it is visible in the array.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   wb_valid_i     writeback bundle valid this cycle
//   wb_we_i        instruction writes a register
//   wb_sel_i       00=ALU, 01=memory, 10=PC+4 (link), 11=illegal
//   wb_alu_i       ALU result
//   wb_mem_i       load data
//   wb_pcplus4_i   PC+4 of the instruction
//   wb_rd_i        destination register (ignored for link writebacks)
//   rs_addr_i      read port A address
//   rt_addr_i      read port B address
//   rs_data_o      read port A data (combinational, bypassed)
//   rt_data_o      read port B data (combinational, bypassed)
//   commit_o       a register write is pending this cycle
//   commit_addr_o  pending write address
//   commit_data_o  pending write data
//   sel_err_o      sticky flag: illegal select seen with valid & we
// -----------------------------------------------------------------------------
module wb_regfile_commit #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int LINK_REG = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid_i,
   input  logic              wb_we_i,
   input  logic [1:0]        wb_sel_i,
   input  logic [DATA_W-1:0] wb_alu_i,
   input  logic [DATA_W-1:0] wb_mem_i,
   input  logic [DATA_W-1:0] wb_pcplus4_i,
   input  logic [ADDR_W-1:0] wb_rd_i,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   output logic              commit_o,
   output logic [ADDR_W-1:0] commit_addr_o,
   output logic [DATA_W-1:0] commit_data_o,
   output logic              sel_err_o
);

   localparam int NREG = 2 ** ADDR_W;

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_MEM  = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;
   localparam logic [1:0] SEL_ILL  = 2'b11;

   localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

   // --------------------------------------------------------------------------
   // Pending (commit) stage
   // --------------------------------------------------------------------------
   logic              commit_q,      commit_d;
   logic [ADDR_W-1:0] commit_addr_q, commit_addr_d;
   logic [DATA_W-1:0] commit_data_q, commit_data_d;
   logic              sel_err_q,     sel_err_d;

   logic              wr_req;
   logic              capture;
   logic              illegal;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   assign wr_req  = wb_valid_i & wb_we_i;
   assign capture = wr_req & (wb_sel_i != SEL_ILL);
   assign illegal = wr_req & (wb_sel_i == SEL_ILL);

   // Link writebacks always target the link register; rd is ignored for them.
   assign wb_addr = (wb_sel_i == SEL_LINK) ? LINK_ADDR : wb_rd_i;

   always_comb begin
      wb_data = wb_alu_i;
      unique case (wb_sel_i)
         SEL_ALU:  wb_data = wb_alu_i;
         SEL_MEM:  wb_data = wb_mem_i;
         SEL_LINK: wb_data = wb_pcplus4_i;
         default:  wb_data = wb_alu_i;   // illegal code is never captured
      endcase
   end

   always_comb begin
      commit_d      = 1'b0;
      commit_addr_d = commit_addr_q;
      commit_data_d = commit_data_q;
      sel_err_d     = sel_err_q | illegal;
      if (capture) begin
         // A write to r0 is captured but never flagged as a commit, so it
         // neither updates the array nor bypasses onto the read ports.
         commit_addr_d = wb_addr;
         commit_data_d = wb_data;
         commit_d      = (wb_addr != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_q      <= 1'b0;
         commit_addr_q <= '0;
         commit_data_q <= '0;
         sel_err_q     <= 1'b0;
      end else begin
         commit_q      <= commit_d;
         commit_addr_q <= commit_addr_d;
         commit_data_q <= commit_data_d;
         sel_err_q     <= sel_err_d;
      end
   end

   assign commit_o      = commit_q;
   assign commit_addr_o = commit_addr_q;
   assign commit_data_o = commit_data_q;
   assign sel_err_o     = sel_err_q;

   // --------------------------------------------------------------------------
   // Register file
   // --------------------------------------------------------------------------
   // Every entry is cleared by reset, which rules out a RAM macro; the array
   // is built from flops. Entry 0 is reset and never written, so it holds 0,
   // and the read ports additionally force address 0 to 0.
   logic [DATA_W-1:0] rf_q [0:NREG-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else if (commit_q && (commit_addr_q != '0)) begin
         rf_q[commit_addr_q] <= commit_data_q;
      end
   end

   // --------------------------------------------------------------------------
   // Read ports with bypass of the pending write
   // --------------------------------------------------------------------------
   logic [ADDR_W-1:0] rd_addr [0:1];
   logic [DATA_W-1:0] rd_data [0:1];

   assign rd_addr[0] = rs_addr_i;
   assign rd_addr[1] = rt_addr_i;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
         always_comb begin
            rd_data[gi] = rf_q[rd_addr[gi]];
            if (rd_addr[gi] == '0) begin
               rd_data[gi] = '0;
            end else if (commit_q && (rd_addr[gi] == commit_addr_q)) begin
               // The pending value is newer than anything in the array.
               rd_data[gi] = commit_data_q;
            end
         end
      end
   endgenerate

   assign rs_data_o = rd_data[0];
   assign rt_data_o = rd_data[1];

endmodule

// File: tb/tb_wb_regfile_commit.sv
module tb_wb_regfile_commit;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst_n;
   logic          wb_valid_i;
   logic          wb_we_i;
   logic [1:0]    wb_sel_i;
   logic [DW-1:0] wb_alu_i;
   logic [DW-1:0] wb_mem_i;
   logic [DW-1:0] wb_pcplus4_i;
   logic [AW-1:0] wb_rd_i;
   logic [AW-1:0] rs_addr_i;
   logic [AW-1:0] rt_addr_i;
   logic [DW-1:0] rs_data_o;
   logic [DW-1:0] rt_data_o;
   logic          commit_o;
   logic [AW-1:0] commit_addr_o;
   logic [DW-1:0] commit_data_o;
   logic          sel_err_o;

   wb_regfile_commit #(.DATA_W(DW), .ADDR_W(AW), .LINK_REG(31)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_valid_i    (wb_valid_i),
      .wb_we_i       (wb_we_i),
      .wb_sel_i      (wb_sel_i),
      .wb_alu_i      (wb_alu_i),
      .wb_mem_i      (wb_mem_i),
      .wb_pcplus4_i  (wb_pcplus4_i),
      .wb_rd_i       (wb_rd_i),
      .rs_addr_i     (rs_addr_i),
      .rt_addr_i     (rt_addr_i),
      .rs_data_o     (rs_data_o),
      .rt_data_o     (rt_data_o),
      .commit_o      (commit_o),
      .commit_addr_o (commit_addr_o),
      .commit_data_o (commit_data_o),
      .sel_err_o     (sel_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } commit_t;

   commit_t exp_q [$];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Monitor: every presented commit is matched against the oldest expected one.
   always @(negedge clk) begin
      if (rst_n && commit_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL commit_unexpected: got addr=%0d data=0x%08h expected none",
                     commit_addr_o, commit_data_o);
         end else begin
            commit_t e;
            e = exp_q.pop_front();
            chk("commit_addr", DW'(commit_addr_o), DW'(e.addr));
            chk("commit_data", commit_data_o, e.data);
         end
      end
   end

   // Drive a bundle just after a rising edge; it is captured at the next one.
   task automatic drive(input logic v, input logic we, input logic [1:0] sel,
                        input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                        input logic [DW-1:0] pc, input logic [AW-1:0] rd,
                        input bit push, input logic [AW-1:0] eaddr,
                        input logic [DW-1:0] edata);
      commit_t e;
      @(posedge clk);
      #1;
      wb_valid_i   = v;
      wb_we_i      = we;
      wb_sel_i     = sel;
      wb_alu_i     = alu;
      wb_mem_i     = mem;
      wb_pcplus4_i = pc;
      wb_rd_i      = rd;
      if (push) begin
         e.addr = eaddr;
         e.data = edata;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic rd2(input string name, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [DW-1:0] ea, input logic [DW-1:0] eb);
      rs_addr_i = a;
      rt_addr_i = b;
      #1;
      chk({name, "_rs"}, rs_data_o, ea);
      chk({name, "_rt"}, rt_data_o, eb);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      wb_valid_i   = 1'b0;
      wb_we_i      = 1'b0;
      wb_sel_i     = 2'b00;
      wb_alu_i     = '0;
      wb_mem_i     = '0;
      wb_pcplus4_i = '0;
      wb_rd_i      = '0;
      rs_addr_i    = '0;
      rt_addr_i    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      for (int i = 0; i < 32; i++) begin
         rs_addr_i = AW'(i);
         rt_addr_i = AW'(31 - i);
         #1;
         chk($sformatf("rst_rs%0d", i), rs_data_o, 32'h0);
         chk($sformatf("rst_rt%0d", 31 - i), rt_data_o, 32'h0);
      end
      chk("rst_commit", DW'(commit_o), 32'h0);
      chk("rst_sel_err", DW'(sel_err_o), 32'h0);

      // ALU writeback to r5: bypass, then array
      drive(1'b1, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 5'd5, 1'b1, 5'd5, 32'h1234_5678);
      idle();
      rd2("alu_bypass", 5'd5, 5'd6, 32'h1234_5678, 32'h0);
      idle();
      chk("alu_commit_clr", DW'(commit_o), 32'h0);
      rd2("alu_array", 5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678);

      // JAL with rd=0 writes r31
      drive(1'b1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0040_0010, 5'd0, 1'b1, 5'd31, 32'h0040_0010);
      idle();
      rd2("jal_bypass", 5'd31, 5'd0, 32'h0040_0010, 32'h0);
      idle();
      rd2("jal_array", 5'd31, 5'd0, 32'h0040_0010, 32'h0);

      // Load into r0 is suppressed
      drive(1'b1, 1'b1, 2'b01, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0);
      idle();
      chk("r0_commit", DW'(commit_o), 32'h0);
      rd2("r0_read", 5'd0, 5'd0, 32'h0, 32'h0);
      idle();
      rd2("r0_after", 5'd0, 5'd5, 32'h0, 32'h1234_5678);

      // Back-to-back writes to r7
      drive(1'b1, 1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd7, 1'b1, 5'd7, 32'h1);
      drive(1'b1, 1'b1, 2'b01, 32'h0, 32'h2, 32'h0, 5'd7, 1'b1, 5'd7, 32'h2);
      rd2("b2b_first", 5'd7, 5'd7, 32'h1, 32'h1);
      idle();
      rd2("b2b_second", 5'd7, 5'd7, 32'h2, 32'h2);
      idle();
      rd2("b2b_array", 5'd7, 5'd7, 32'h2, 32'h2);

      // Illegal select without we is ignored
      drive(1'b1, 1'b0, 2'b11, 32'h5555_5555, 32'h0, 32'h0, 5'd3, 1'b0, 5'd0, 32'h0);
      idle();
      chk("ill_nowe_err", DW'(sel_err_o), 32'h0);

      // Illegal select with we: no write, sticky error
      drive(1'b1, 1'b1, 2'b11, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 5'd3, 1'b0, 5'd0, 32'h0);
      idle();
      chk("ill_commit", DW'(commit_o), 32'h0);
      chk("ill_err", DW'(sel_err_o), 32'h1);
      rd2("ill_r3", 5'd3, 5'd3, 32'h0, 32'h0);
      idle();
      idle();
      chk("ill_err_sticky", DW'(sel_err_o), 32'h1);
      rd2("ill_r3_later", 5'd3, 5'd7, 32'h0, 32'h2);

      // Reset while a write to r9 is pending
      drive(1'b1, 1'b1, 2'b00, 32'h0000_AA55, 32'h0, 32'h0, 5'd9, 1'b0, 5'd0, 32'h0);
      idle();
      chk("pend_commit", DW'(commit_o), 32'h1);
      chk("pend_addr", DW'(commit_addr_o), 32'd9);
      rst_n = 1'b0;
      #1;
      chk("arst_commit", DW'(commit_o), 32'h0);
      chk("arst_addr", DW'(commit_addr_o), 32'h0);
      chk("arst_data", commit_data_o, 32'h0);
      chk("arst_err", DW'(sel_err_o), 32'h0);
      rd2("arst_r9", 5'd9, 5'd31, 32'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      rd2("post_rst", 5'd9, 5'd7, 32'h0, 32'h0);
      idle();
      idle();
      rd2("post_rst_idle", 5'd9, 5'd5, 32'h0, 32'h0);

      chk("scoreboard_empty", DW'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
